// File: rtl/tb_sim_ctrl_pkg.sv
// rtl/tb_sim_ctrl_pkg.sv - register map, status bit positions and state type for the sim control slave
package tb_sim_ctrl_pkg;

  localparam logic [1:0] REG_EXIT   = 2'd0;
  localparam logic [1:0] REG_PUTC   = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam logic [1:0] REG_CYCLES = 2'd3;

  localparam int unsigned STATUS_FULL_BIT  = 0;
  localparam int unsigned STATUS_EXIT_BIT  = 1;
  localparam int unsigned STATUS_COUNT_LSB = 8;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_EXITED   = 2'd1,
    ST_DRAINED  = 2'd2,
    ST_FINISHED = 2'd3
  } state_e;

endpackage

// File: rtl/tb_char_fifo.sv
// rtl/tb_char_fifo.sv - first-word-fall-through byte FIFO for the console character stream
module tb_char_fifo #(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [7:0]               wdata,
  input  logic                     pop,
  output logic [7:0]               rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count_q;
  logic          do_push;
  logic          do_pop;

  // Guard here too so a misbehaving caller can never corrupt the pointers.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = empty ? 8'h00 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/tb_sim_ctrl_slave.sv
// rtl/tb_sim_ctrl_slave.sv - TCDM slave for simulation exit code, console output and cycle count
module tb_sim_ctrl_slave
  import tb_sim_ctrl_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter int unsigned FINISH_DELAY = 10
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  input  logic [31:0] add_i,
  input  logic        wen_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] data_i,
  output logic        gnt_o,
  output logic [31:0] r_data_o,
  output logic        r_valid_o,
  output logic [7:0]  char_o,
  output logic        char_valid_o,
  input  logic        char_ready_i,
  input  logic        sleeping_i,
  output logic        done_o,
  output logic [31:0] errors_o,
  output logic        finish_o
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [31:0] DELAY_LAST = (FINISH_DELAY == 0) ? 32'd0 : 32'(FINISH_DELAY - 1);

  state_e        state_q, state_d;
  logic [31:0]   delay_q, delay_d;
  logic [31:0]   cycle_cnt;
  logic [31:0]   rdata_d;
  logic [31:0]   r_data_q;
  logic          r_valid_q;
  logic [1:0]    reg_sel;
  logic          putc_wr;
  logic          exit_wr;
  logic          exit_valid;
  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [7:0]    count8;
  logic          unused_inputs;

  assign unused_inputs = ^{add_i[31:4], add_i[1:0], be_i};

  assign reg_sel = add_i[3:2];
  assign putc_wr = req_i & ~wen_i & (reg_sel == REG_PUTC);
  assign gnt_o   = req_i & ~(putc_wr & fifo_full);

  assign fifo_push = putc_wr & ~fifo_full;
  assign fifo_pop  = ~fifo_empty & char_ready_i;
  assign exit_wr   = gnt_o & ~wen_i & (reg_sel == REG_EXIT) & (state_q == ST_RUN);

  assign exit_valid   = (state_q != ST_RUN);
  assign char_valid_o = ~fifo_empty;
  assign count8       = 8'(fifo_count);

  tb_char_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .push  (fifo_push),
    .wdata (data_i[7:0]),
    .pop   (fifo_pop),
    .rdata (char_o),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Read data is captured at grant time, so STATUS and CYCLES reflect the granting cycle.
  always_comb begin
    rdata_d = '0;
    if (wen_i) begin
      case (reg_sel)
        REG_STATUS: begin
          rdata_d[STATUS_COUNT_LSB +: 8] = count8;
          rdata_d[STATUS_EXIT_BIT]       = exit_valid;
          rdata_d[STATUS_FULL_BIT]       = fifo_full;
        end
        REG_CYCLES: rdata_d = cycle_cnt;
        default:    rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid_q <= 1'b0;
      r_data_q  <= '0;
      cycle_cnt <= '0;
      errors_o  <= '0;
    end else begin
      r_valid_q <= gnt_o;
      r_data_q  <= gnt_o ? rdata_d : 32'd0;
      cycle_cnt <= cycle_cnt + 32'd1;
      if (exit_wr) begin
        errors_o <= data_i;
      end
    end
  end

  assign r_valid_o = r_valid_q;
  assign r_data_o  = r_valid_q ? r_data_q : 32'd0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_RUN;
      delay_q <= '0;
    end else begin
      state_q <= state_d;
      delay_q <= delay_d;
    end
  end

  always_comb begin
    state_d = state_q;
    delay_d = delay_q;
    case (state_q)
      ST_RUN: begin
        if (exit_wr) begin
          state_d = ST_EXITED;
        end
      end
      ST_EXITED: begin
        if (sleeping_i && fifo_empty) begin
          state_d = ST_DRAINED;
        end
      end
      ST_DRAINED: begin
        if (delay_q == DELAY_LAST) begin
          state_d = ST_FINISHED;
        end else begin
          delay_d = delay_q + 32'd1;
        end
      end
      default: state_d = ST_FINISHED;
    endcase
  end

  assign done_o   = (state_q == ST_DRAINED) || (state_q == ST_FINISHED);
  assign finish_o = (state_q == ST_FINISHED);

endmodule

// File: tb/tb_tb_sim_ctrl_slave.sv
// tb/tb_tb_sim_ctrl_slave.sv - directed self-checking bench for tb_sim_ctrl_slave
module tb_tb_sim_ctrl_slave;
  import tb_sim_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic [31:0] add = '0;
  logic        wen = 1'b1;
  logic [3:0]  be = 4'h1;
  logic [31:0] data = '0;
  logic        gnt;
  logic [31:0] r_data;
  logic        r_valid;
  logic [7:0]  char_data;
  logic        char_valid;
  logic        char_ready = 1'b0;
  logic        sleeping = 1'b0;
  logic        done;
  logic [31:0] errors;
  logic        finish;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  tb_sim_ctrl_slave #(
    .FIFO_DEPTH   (8),
    .FINISH_DELAY (10)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .req_i        (req),
    .add_i        (add),
    .wen_i        (wen),
    .be_i         (be),
    .data_i       (data),
    .gnt_o        (gnt),
    .r_data_o     (r_data),
    .r_valid_o    (r_valid),
    .char_o       (char_data),
    .char_valid_o (char_valid),
    .char_ready_i (char_ready),
    .sleeping_i   (sleeping),
    .done_o       (done),
    .errors_o     (errors),
    .finish_o     (finish)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; returns at the falling edge where the response is visible.
  task automatic bus(input logic [1:0] sel, input logic rd, input logic [31:0] wdata,
                     output logic [31:0] rdata);
    int t = 0;
    req  = 1'b1;
    add  = {28'h0, sel, 2'b00};
    wen  = rd;
    data = wdata;
    #1;
    while (!gnt && t < 50) begin
      @(negedge clk);
      #1;
      t++;
    end
    check("gnt", 32'(gnt), 32'd1);
    @(posedge clk);
    #1;
    req = 1'b0;
    wen = 1'b1;
    @(negedge clk);
    check("r_valid", 32'(r_valid), 32'd1);
    rdata = r_data;
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] c1;
    logic [31:0] c2;
    int k;

    #2;
    check("rst_r_valid", 32'(r_valid), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_finish", 32'(finish), 32'd0);
    check("rst_char_valid", 32'(char_valid), 32'd0);
    check("rst_errors", errors, 32'd0);

    @(negedge clk);
    rst_n = 1'b1;
    bus(REG_CYCLES, 1'b1, 32'd0, rd);
    check("cycles_first", rd, 32'd0);
    @(negedge clk);
    check("idle_r_valid", 32'(r_valid), 32'd0);
    check("idle_r_data", r_data, 32'd0);

    bus(REG_CYCLES, 1'b1, 32'd0, c1);
    repeat (4) @(negedge clk);
    bus(REG_CYCLES, 1'b1, 32'd0, c2);
    check("cycles_delta", c2 - c1, 32'd5);

    force dut.cycle_cnt = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.cycle_cnt;
    bus(REG_CYCLES, 1'b1, 32'd0, rd);
    check("cycles_max", rd, 32'hFFFF_FFFF);
    bus(REG_CYCLES, 1'b1, 32'd0, rd);
    check("cycles_wrap", rd, 32'd0);
    bus(REG_EXIT, 1'b1, 32'd0, rd);
    check("exit_read", rd, 32'd0);

    char_ready = 1'b1;
    bus(REG_PUTC, 1'b0, 32'hFFFF_FF41, rd);
    check("putc_a", 32'(char_data), 32'h41);
    check("putc_a_valid", 32'(char_valid), 32'd1);
    bus(REG_PUTC, 1'b0, 32'hABCD_EF42, rd);
    check("putc_b", 32'(char_data), 32'h42);
    @(negedge clk);
    check("putc_empty", 32'(char_valid), 32'd0);
    check("putc_empty_char", 32'(char_data), 32'd0);

    char_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus(REG_PUTC, 1'b0, 32'h10 + i, rd);
    end
    bus(REG_STATUS, 1'b1, 32'd0, rd);
    check("status_full", rd, 32'h0000_0801);
    req  = 1'b1;
    add  = {28'h0, REG_PUTC, 2'b00};
    wen  = 1'b0;
    data = 32'h18;
    #1;
    check("gnt_full", 32'(gnt), 32'd0);
    @(negedge clk);
    #1;
    check("gnt_full_hold", 32'(gnt), 32'd0);
    char_ready = 1'b1;
    @(posedge clk);
    #1;
    char_ready = 1'b0;
    check("gnt_after_pop", 32'(gnt), 32'd1);
    @(posedge clk);
    #1;
    req = 1'b0;
    wen = 1'b1;
    @(negedge clk);
    check("ninth_r_valid", 32'(r_valid), 32'd1);
    char_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("drain_order", 32'(char_data), 32'h11 + i);
      @(negedge clk);
    end
    check("drain_empty", 32'(char_valid), 32'd0);

    char_ready = 1'b0;
    bus(REG_PUTC, 1'b0, 32'hA1, rd);
    bus(REG_PUTC, 1'b0, 32'hA2, rd);
    bus(REG_PUTC, 1'b0, 32'hA3, rd);
    bus(REG_EXIT, 1'b0, 32'h1234_5607, rd);
    check("exit_latch", errors, 32'h1234_5607);
    bus(REG_EXIT, 1'b0, 32'h9, rd);
    check("exit_second_ignored", errors, 32'h1234_5607);
    bus(REG_STATUS, 1'b1, 32'd0, rd);
    check("status_exit_q3", rd, 32'h0000_0302);
    sleeping = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("done_blocked", 32'(done), 32'd0);
    end
    char_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("drained_fifo", 32'(char_valid), 32'd0);
    check("done_not_yet", 32'(done), 32'd0);
    @(negedge clk);
    check("done_after_drain", 32'(done), 32'd1);
    check("finish_not_yet", 32'(finish), 32'd0);

    char_ready = 1'b0;
    bus(REG_PUTC, 1'b0, 32'hB1, rd);
    bus(REG_PUTC, 1'b0, 32'hB2, rd);
    check("drained_push", 32'(char_valid), 32'd1);
    req = 1'b1;
    add = {28'h0, REG_CYCLES, 2'b00};
    wen = 1'b1;
    @(posedge clk);
    #1;
    check("mid_read_r_valid", 32'(r_valid), 32'd1);
    check("mid_read_done", 32'(done), 32'd1);
    rst_n = 1'b0;
    req = 1'b0;
    #1;
    check("rst2_r_valid", 32'(r_valid), 32'd0);
    check("rst2_done", 32'(done), 32'd0);
    check("rst2_finish", 32'(finish), 32'd0);
    check("rst2_char_valid", 32'(char_valid), 32'd0);
    check("rst2_char", 32'(char_data), 32'd0);
    check("rst2_errors", errors, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus(REG_STATUS, 1'b1, 32'd0, rd);
    check("rst2_status", rd, 32'd0);

    sleeping   = 1'b0;
    char_ready = 1'b1;
    bus(REG_EXIT, 1'b0, 32'h0, rd);
    bus(REG_EXIT, 1'b0, 32'h5, rd);
    check("exit_first_wins", errors, 32'h0);
    bus(REG_STATUS, 1'b0, 32'hFFFF_FFFF, rd);
    bus(REG_CYCLES, 1'b0, 32'hFFFF_FFFF, rd);
    bus(REG_STATUS, 1'b1, 32'd0, rd);
    check("status_exited", rd, 32'h0000_0002);
    sleeping = 1'b1;
    #1;
    check("done_pre", 32'(done), 32'd0);
    @(negedge clk);
    check("done_rise", 32'(done), 32'd1);
    check("finish_low", 32'(finish), 32'd0);
    k = 0;
    while (!finish && k < 30) begin
      @(negedge clk);
      k++;
    end
    check("finish_delay", 32'(k), 32'd10);
    bus(REG_STATUS, 1'b1, 32'd0, rd);
    check("status_finished", rd, 32'h0000_0002);
    check("finished_done", 32'(done), 32'd1);
    check("finished_finish", 32'(finish), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
